// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command sequencer for the registered ALU: assembles A/B/FUN,
// pulses ALU_EN, captures the result and hands it to the transmitter.
module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    FUNC_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPR = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD,
  parameter int                    TIMEOUT     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUNC_WIDTH-1:0] ALU_FUN,
  output logic                  ALU_EN,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  ERR,
  output logic                  BUSY
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_ALU, SEND} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] a_nxt, b_nxt, tx_data_nxt;
  logic [FUNC_WIDTH-1:0] fun_nxt;
  logic                  en_nxt, tx_valid_nxt, err_nxt, busy_nxt;
  logic                  timeout;
  logic                  is_cmd;

  // cnt counts cycles since ALU_EN, so ERR lands exactly TIMEOUT cycles after it
  assign timeout = (state == WAIT_ALU) && !ALU_OUT_VALID && (cnt == CNT_W'(TIMEOUT - 1));
  assign is_cmd  = (RX_DATA == CMD_ALU_OPR) || (RX_DATA == CMD_ALU_NOP);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (RX_VALID && RX_DATA == CMD_ALU_OPR)      state_nxt = GET_A;
        else if (RX_VALID && RX_DATA == CMD_ALU_NOP) state_nxt = GET_FUN;
      end
      GET_A:    if (RX_VALID) state_nxt = GET_B;
      GET_B:    if (RX_VALID) state_nxt = GET_FUN;
      GET_FUN:  if (RX_VALID) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_ALU;
      WAIT_ALU: begin
        if (ALU_OUT_VALID) state_nxt = SEND;
        else if (timeout)  state_nxt = IDLE;
      end
      SEND:     if (TX_READY) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_nxt        = ALU_A;
    b_nxt        = ALU_B;
    fun_nxt      = ALU_FUN;
    tx_data_nxt  = TX_DATA;
    tx_valid_nxt = TX_VALID;
    cnt_nxt      = cnt;
    en_nxt       = 1'b0;
    err_nxt      = 1'b0;
    busy_nxt     = (state_nxt != IDLE);
    case (state)
      IDLE:  err_nxt = RX_VALID && !is_cmd;
      GET_A: if (RX_VALID) a_nxt = RX_DATA;
      GET_B: if (RX_VALID) b_nxt = RX_DATA;
      GET_FUN: begin
        if (RX_VALID) begin
          fun_nxt = RX_DATA[FUNC_WIDTH-1:0];
          en_nxt  = 1'b1;
          cnt_nxt = '0;
        end
      end
      ISSUE: begin
        err_nxt = RX_VALID;
        cnt_nxt = cnt + 1'b1;
      end
      WAIT_ALU: begin
        err_nxt = RX_VALID || timeout;
        cnt_nxt = cnt + 1'b1;
        if (ALU_OUT_VALID) begin
          tx_data_nxt  = ALU_OUT;
          tx_valid_nxt = 1'b1;
        end
      end
      SEND: begin
        err_nxt = RX_VALID;
        if (TX_READY) tx_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= '0;
      ALU_EN   <= 1'b0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
      cnt      <= '0;
    end else begin
      ALU_A    <= a_nxt;
      ALU_B    <= b_nxt;
      ALU_FUN  <= fun_nxt;
      ALU_EN   <= en_nxt;
      TX_DATA  <= tx_data_nxt;
      TX_VALID <= tx_valid_nxt;
      ERR      <= err_nxt;
      BUSY     <= busy_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer directly upstream of the registered ALU. It takes a byte stream from the serial receive path, assembles operand A, operand B and function code, and issues a single-cycle ALU_EN. It captures ALU_OUT on ALU_OUT_VALID and presents the result to the transmit path on a valid/ready handshake. It detects bad commands, ALU non-response and receive overruns.

Parameters:
DATA_WIDTH, 8, operand/result/byte width
FUNC_WIDTH, 4, ALU function code width (low bits of function byte)
CMD_ALU_OPR, 8'hCC, command: operands follow, then function
CMD_ALU_NOP, 8'hDD, command: reuse stored operands, function follows
TIMEOUT, 16, max cycles waiting for ALU_OUT_VALID after ALU_EN

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
RX_DATA  in  DATA_WIDTH  received byte
RX_VALID  in  1  one-cycle strobe, RX_DATA valid
ALU_OUT  in  DATA_WIDTH  ALU result
ALU_OUT_VALID  in  1  ALU result strobe
ALU_A  out  DATA_WIDTH  operand A register
ALU_B  out  DATA_WIDTH  operand B register
ALU_FUN  out  FUNC_WIDTH  function code register
ALU_EN  out  1  one-cycle ALU enable pulse
TX_DATA  out  DATA_WIDTH  result byte to transmitter
TX_VALID  out  1  TX_DATA valid, held until accepted
TX_READY  in  1  transmitter accepts when TX_VALID&TX_READY
ERR  out  1  one-cycle error pulse
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: RST asynchronous, active-low; clock CLK. All outputs, ALU_A/ALU_B/ALU_FUN, result register, timeout counter = 0; state = IDLE. Reset mid-frame discards the partial frame and any pending TX; no ALU_EN or TX_VALID is produced afterwards.
- All outputs are registered.
- States: IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_ALU, SEND.
- IDLE: on RX_VALID: CC -> GET_A; DD -> GET_FUN; any other byte -> ERR pulse, stay IDLE.
- GET_A: on RX_VALID, ALU_A <= RX_DATA, -> GET_B. GET_B: on RX_VALID, ALU_B <= RX_DATA, -> GET_FUN.
- GET_FUN: on RX_VALID, ALU_FUN <= RX_DATA[FUNC_WIDTH-1:0] (upper bits ignored), -> ISSUE.
- Operands persist across frames; DD uses the last stored A/B (0 after reset).
- ISSUE: ALU_EN = 1 for exactly one cycle; timeout counter cleared; -> WAIT_ALU.
- WAIT_ALU: on ALU_OUT_VALID, TX_DATA <= ALU_OUT, TX_VALID <= 1, -> SEND. Counter increments each cycle. If it reaches TIMEOUT without valid: ERR pulse, -> IDLE, no TX.
- ALU_OUT_VALID outside WAIT_ALU is ignored.
- Latency: function byte strobe at cycle N -> ALU_EN high in N+1 -> (ALU valid N+2) -> TX_VALID high N+3.
- SEND: TX_VALID and TX_DATA are held stable until the cycle TX_VALID&TX_READY. TX_VALID drops the next cycle; -> IDLE.
- Overrun: RX_VALID while in ISSUE, WAIT_ALU or SEND: byte dropped, ERR pulse, state unaffected.
- RX_VALID in the same cycle that SEND completes is also dropped (ERR).
- No inter-byte timeout; partial frames wait indefinitely until reset.
- Function codes the ALU does not implement are still issued; the result is forwarded as delivered.
- Arithmetic is performed entirely in the ALU; this block does no width conversion.

Test Plan:
- Send CC,05,03,00 with TX_READY=1 -> ALU_A=05, ALU_B=03, ALU_FUN=0, single ALU_EN pulse one cycle after the FUN strobe. TX_DATA=08 with TX_VALID one cycle; BUSY low after.
- Then send DD,02 -> ALU_EN with A=05, B=03, FUN=2 -> TX_DATA=0F; no re-entry of operands.
- Send 7E in IDLE -> one ERR pulse, no ALU_EN, no TX_VALID, state IDLE. A following CC,0A,04,01 -> TX_DATA=06.
- Hold TX_READY=0 for 10 cycles after result 08 -> TX_VALID/TX_DATA=08 stable for all 10 cycles. Inject RX_VALID byte 55 during the hold -> ERR pulse, byte dropped. Raise TX_READY -> single transfer.
- Tie ALU_OUT_VALID=0 and send CC,01,01,00 -> ERR pulse TIMEOUT(16) cycles after ALU_EN, return to IDLE, TX_VALID never asserted.
- Send CC,09, then assert RST low for 1 cycle -> all outputs 0. A subsequent DD,00 uses A=0, B=0 -> TX_DATA=00.
